// File: rtl/mult4u_dmr_sched_if.sv
// Request, response and multiplier signal bundle for mult4u_dmr_sched.
// master: requesters, response consumer and multiplier side; slave: the scheduler.
interface mult4u_dmr_sched_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       req_valid;
    logic [3:0]       req_a0;
    logic [3:0]       req_b0;
    logic [3:0]       req_a1;
    logic [3:0]       req_b1;
    logic [1:0]       req_ready;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_p;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [7:0]       resp_p;
    logic             resp_err;
    logic [CNT_W-1:0] mis_cnt;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_ready,
        input  mul_a, mul_b,
        output mul_p,
        input  resp_valid,
        output resp_ready,
        input  resp_id, resp_p, resp_err, mis_cnt
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_ready,
        output mul_a, mul_b,
        input  mul_p,
        output resp_valid,
        input  resp_ready,
        output resp_id, resp_p, resp_err, mis_cnt
    );
endinterface

// File: rtl/mult4u_dmr_sched.sv
// Time-redundant scheduler sharing one 4x4 unsigned multiplier between two requesters.
// Optional macro MULT4U_SCHED_SWAP_EN: second run of each pair uses swapped operands.
module mult4u_dmr_sched #(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mult4u_dmr_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic             id_q, id_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       mul_a_q, mul_a_d;
    logic [3:0]       mul_b_q, mul_b_d;
    logic [7:0]       p1_q, p1_d;
    logic [7:0]       resp_p_q, resp_p_d;
    logic             resp_err_q, resp_err_d;
    logic [1:0]       retry_q, retry_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [1:0]       grant;
    logic             xfer;
    logic             gnt_id;
    logic             mismatch;
    logic             retry_ok;

    // rr_last_q remembers the last served requester; a tie goes to the other one.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign xfer     = |grant;
    assign gnt_id   = grant[1];
    assign mismatch = (bus.mul_p != p1_q);
    assign retry_ok = (retry_q < RETRY_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (xfer) state_d = RUN1;
            RUN1: state_d = RUN2;
            RUN2: state_d = (mismatch && retry_ok) ? RUN1 : RESP;
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_last_d  = rr_last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        p1_d       = p1_q;
        resp_p_d   = resp_p_q;
        resp_err_d = resp_err_q;
        retry_d    = retry_q;
        mis_cnt_d  = mis_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    rr_last_d = gnt_id;
                    id_d      = gnt_id;
                    a_d       = gnt_id ? bus.req_a1 : bus.req_a0;
                    b_d       = gnt_id ? bus.req_b1 : bus.req_b0;
                    mul_a_d   = gnt_id ? bus.req_a1 : bus.req_a0;
                    mul_b_d   = gnt_id ? bus.req_b1 : bus.req_b0;
                    retry_d   = 2'd0;
                end
            end
            RUN1: begin
                p1_d = bus.mul_p;
`ifdef MULT4U_SCHED_SWAP_EN
                mul_a_d = b_q;
                mul_b_d = a_q;
`else
                mul_a_d = a_q;
                mul_b_d = b_q;
`endif
            end
            RUN2: begin
                if (mismatch) begin
                    if (mis_cnt_q != '1) begin
                        mis_cnt_d = mis_cnt_q + CNT_ONE;
                    end
                    if (retry_ok) begin
                        retry_d = retry_q + 2'd1;
                        mul_a_d = a_q;
                        mul_b_d = b_q;
                    end else begin
                        resp_p_d   = p1_q;
                        resp_err_d = 1'b1;
                    end
                end else begin
                    resp_p_d   = p1_q;
                    resp_err_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q  <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            mul_a_q    <= 4'd0;
            mul_b_q    <= 4'd0;
            p1_q       <= 8'd0;
            resp_p_q   <= 8'd0;
            resp_err_q <= 1'b0;
            retry_q    <= 2'd0;
            mis_cnt_q  <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            p1_q       <= p1_d;
            resp_p_q   <= resp_p_d;
            resp_err_q <= resp_err_d;
            retry_q    <= retry_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    always_comb begin
        bus.req_ready  = grant;
        bus.resp_valid = (state_q == RESP);
        bus.resp_id    = id_q;
        bus.resp_p     = resp_p_q;
        bus.resp_err   = resp_err_q;
        bus.mul_a      = mul_a_q;
        bus.mul_b      = mul_b_q;
        bus.mis_cnt    = mis_cnt_q;
    end
endmodule

// File: tb/tb_mult4u_dmr_sched.sv
// Self-checking bench for mult4u_dmr_sched: directed and randomized operations
// checked against a cycle-count/arithmetic model of the redundant-run protocol.
module tb_mult4u_dmr_sched;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mult4u_dmr_sched_if #(.CNT_W(CNT_W)) bus ();

    mult4u_dmr_sched #(
        .MAX_RETRY(MAX_RETRY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: ideal product, optional one-cycle bit flip, optional +1 when mul_a is 6.
    bit corrupt = 1'b0;
    bit plus_one = 1'b0;
    assign bus.mul_p = (({4'b0, bus.mul_a} * {4'b0, bus.mul_b})
                        + ((plus_one && bus.mul_a == 4'd6) ? 8'd1 : 8'd0))
                       ^ (corrupt ? 8'h01 : 8'h00);

    int checks      = 0;
    int errors      = 0;
    int mis_model   = 0;
    int last_served = 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic [3:0] a1, input logic [3:0] b1);
        bus.req_valid = valid;
        bus.req_a0    = a0;
        bus.req_b0    = b0;
        bus.req_a1    = a1;
        bus.req_b1    = b1;
    endtask

    // Called at a falling edge with the DUT idle. inj = pairs whose second run gets a bit
    // flip, eff = mismatching pairs the operation is expected to see, stall = extra RESP cycles.
    task automatic runOp(input logic [1:0] valid, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1, input int inj,
                         input int eff, input int stall, input bit hold_valid);
        int g, pairs, mism, lat;
        bit exp_err;
        logic [3:0] ea, eb;
        logic [7:0] ep;
        applyStimulus(valid, a0, b0, a1, b1);
        bus.resp_ready = (stall == 0);
        #1;
        if (valid == 2'b11) g = (last_served == 0) ? 1 : 0;
        else                g = (valid == 2'b10) ? 1 : 0;
        checkOutput("req_ready_grant", 32'(bus.req_ready), (g == 1) ? 32'd2 : 32'd1);
        last_served = g;
        ea      = (g == 1) ? a1 : a0;
        eb      = (g == 1) ? b1 : b0;
        ep      = 8'(int'(ea) * int'(eb));
        mism    = (eff > MAX_RETRY) ? MAX_RETRY + 1 : eff;
        pairs   = (eff > MAX_RETRY) ? MAX_RETRY + 1 : eff + 1;
        lat     = 1 + 2 * pairs;
        exp_err = (eff > MAX_RETRY);
        mis_model = (mis_model + mism > CNT_MAX) ? CNT_MAX : mis_model + mism;
        @(posedge clk);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            checkOutput("resp_valid_timing", 32'(bus.resp_valid), 32'(n == lat));
            checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (n < lat && (n % 2) == 1) begin
                checkOutput("mul_a_first_run", 32'(bus.mul_a), 32'(ea));
                checkOutput("mul_b_first_run", 32'(bus.mul_b), 32'(eb));
            end
            if (n < lat && (n % 2) == 0) begin
`ifdef MULT4U_SCHED_SWAP_EN
                checkOutput("mul_a_second_run", 32'(bus.mul_a), 32'(eb));
                checkOutput("mul_b_second_run", 32'(bus.mul_b), 32'(ea));
`else
                checkOutput("mul_a_second_run", 32'(bus.mul_a), 32'(ea));
                checkOutput("mul_b_second_run", 32'(bus.mul_b), 32'(eb));
`endif
            end
            if (n == lat) begin
                checkOutput("resp_id", 32'(bus.resp_id), 32'(g));
                checkOutput("resp_p", 32'(bus.resp_p), 32'(ep));
                checkOutput("resp_err", 32'(bus.resp_err), 32'(exp_err));
                checkOutput("mis_cnt", 32'(bus.mis_cnt), 32'(mis_model));
            end
            corrupt = ((n % 2) == 0) && ((n / 2) <= inj) && (n < lat);
            if (!hold_valid) begin
                applyStimulus(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
        end
        corrupt = 1'b0;
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("stall_id", 32'(bus.resp_id), 32'(g));
            checkOutput("stall_p", 32'(bus.resp_p), 32'(ep));
            checkOutput("stall_err", 32'(bus.resp_err), 32'(exp_err));
            checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
            if (s == stall) bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        int v, f;
        applyStimulus(2'b11, 4'd5, 4'd5, 4'd5, 4'd5);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_mul_a", 32'(bus.mul_a), 32'd0);
        checkOutput("rst_mul_b", 32'(bus.mul_b), 32'd0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_id", 32'(bus.resp_id), 32'd0);
        checkOutput("rst_resp_p", 32'(bus.resp_p), 32'd0);
        checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
        checkOutput("rst_mis_cnt", 32'(bus.mis_cnt), 32'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] tie arbitration");
        for (int i = 0; i < 4; i++) runOp(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 0, 0, 0, 1'b1);

        $display("[TB] single op 13*11");
        runOp(2'b01, 4'd13, 4'd11, 4'd0, 4'd0, 0, 0, 0, 1'b0);

        $display("[TB] transient fault 7*9");
        runOp(2'b01, 4'd7, 4'd9, 4'd1, 4'd1, 1, 1, 0, 1'b0);

        $display("[TB] persistent position-dependent fault 2*6");
        plus_one = 1'b1;
`ifdef MULT4U_SCHED_SWAP_EN
        runOp(2'b01, 4'd2, 4'd6, 4'd0, 4'd0, 0, 99, 0, 1'b0);
`else
        runOp(2'b01, 4'd2, 4'd6, 4'd0, 4'd0, 0, 0, 0, 1'b0);
`endif
        plus_one = 1'b0;

        $display("[TB] backpressure");
        runOp(2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 0, 0, 5, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(1, 3);
            f = $urandom_range(0, 3);
            runOp(2'(v), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), f, f,
                  $urandom_range(0, 2), 1'($urandom));
        end

        $display("[TB] reset during RUN2");
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd11, 4'd13);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_resp_valid_pre", 32'(bus.resp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("abort_mul_a", 32'(bus.mul_a), 32'd0);
        checkOutput("abort_mul_b", 32'(bus.mul_b), 32'd0);
        checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("abort_resp_id", 32'(bus.resp_id), 32'd0);
        checkOutput("abort_resp_p", 32'(bus.resp_p), 32'd0);
        checkOutput("abort_resp_err", 32'(bus.resp_err), 32'd0);
        checkOutput("abort_mis_cnt", 32'(bus.mis_cnt), 32'd0);
        mis_model   = 0;
        last_served = 1;
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        end

        $display("[TB] tie after reset favours requester 0");
        runOp(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 0, 0, 0, 1'b1);

        $display("[TB] mismatch counter saturation");
        for (int i = 0; i < 90; i++) begin
            runOp(2'b01, 4'($urandom), 4'($urandom), 4'd0, 4'd0, 3, 3, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
